// File: rtl/nn_layer_sequencer.sv
// Frame sequencer for up to three accumulate-then-ReLU dense layers: releases layer resets in order.
// Optional performance counters (frame_cnt, stall_cnt) are enabled by defining NN_SEQ_PERF_EN.
//
//  state | meaning
//  IDLE  | all layers in reset, waiting for a frame handshake
//  RUN1  | layer 1 accumulating / ReLU (IN_SIZE_1+1 cycles)
//  RUN2  | layer 2 running, layer 1 held released as its input
//  RUN3  | layer 3 running, layers 1-2 held released
//  DONE  | active layers frozen post-ReLU, result offered downstream
module nn_layer_sequencer #(
   parameter int NUM_LAYERS = 3,
   parameter int IN_SIZE_1  = 26,
   parameter int IN_SIZE_2  = 64,
   parameter int IN_SIZE_3  = 32,
   parameter int CNT_W      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        capture_en,
   output logic [2:0]  layer_rst,
   output logic [2:0]  layer_busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] frame_cnt,
   output logic [15:0] stall_cnt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN1 = 3'd1,
      S_RUN2 = 3'd2,
      S_RUN3 = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LIM_1 = CNT_W'(IN_SIZE_1);
   localparam logic [CNT_W-1:0] LIM_2 = CNT_W'(IN_SIZE_2);
   localparam logic [CNT_W-1:0] LIM_3 = CNT_W'(IN_SIZE_3);
   // In DONE only the active layers are released; unused layers stay in reset.
   localparam logic [2:0] DONE_RST = 3'(3'b111 << NUM_LAYERS);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      in_ready   = 1'b0;
      layer_rst  = 3'b111;
      layer_busy = 3'b000;
      out_valid  = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = S_RUN1;
               cnt_d   = '0;
            end
         end
         S_RUN1: begin
            layer_rst  = 3'b110;
            layer_busy = 3'b001;
            if (cnt_q == LIM_1) begin
               cnt_d   = '0;
               state_d = (NUM_LAYERS == 1) ? S_DONE : S_RUN2;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN2: begin
            layer_rst  = 3'b100;
            layer_busy = 3'b010;
            if (cnt_q == LIM_2) begin
               cnt_d   = '0;
               state_d = (NUM_LAYERS == 2) ? S_DONE : S_RUN3;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN3: begin
            layer_rst  = 3'b000;
            layer_busy = 3'b100;
            if (cnt_q == LIM_3) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            layer_rst = DONE_RST;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The only Mealy output: latch strobe must coincide with the accepting cycle.
   assign capture_en = (state_q == S_IDLE) && in_valid && !rst;

`ifdef NN_SEQ_PERF_EN
   logic [15:0] frame_q, stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q <= '0;
         stall_q <= '0;
      end else begin
         if (out_valid && out_ready) begin
            frame_q <= frame_q + 16'd1;
         end
         if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
      end
   end

   assign frame_cnt = frame_q;
   assign stall_cnt = stall_q;
`else
   assign frame_cnt = 16'd0;
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer: directed frames plus random traffic against a timeline model.
module tb_nn_layer_sequencer;

   localparam int NL = 3;
   int LEN [3] = '{27, 65, 33};

   logic        clk = 1'b0;
   logic        rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, capture_en, out_valid;
   logic [2:0]  layer_rst, layer_busy;
   logic [15:0] frame_cnt, stall_cnt;

   logic        rst1 = 1'b1, iv1 = 1'b0, ordy1 = 1'b0;
   logic        in_ready1, cap1, ov1;
   logic [2:0]  lrst1, busy1;
   logic [15:0] fc1, sc1;

   always #5 clk = ~clk;

   nn_layer_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .capture_en(capture_en), .layer_rst(layer_rst), .layer_busy(layer_busy),
      .out_valid(out_valid), .out_ready(out_ready),
      .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
   );

   nn_layer_sequencer #(.NUM_LAYERS(1)) dut1 (
      .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(in_ready1),
      .capture_en(cap1), .layer_rst(lrst1), .layer_busy(busy1),
      .out_valid(ov1), .out_ready(ordy1),
      .frame_cnt(fc1), .stall_cnt(sc1)
   );

   int n_cmp = 0, n_bad = 0, cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: a frame is a timeline of LEN[k] cycles per layer, counted from the accept.
   bit m_act = 0;
   int m_t = 0, m_frame = 0, m_stall = 0;

   function automatic int phase(int t);
      int acc = 0;
      for (int k = 0; k < NL; k++) begin
         acc += LEN[k];
         if (t <= acc) return k + 1;
      end
      return NL + 1;
   endfunction

   task automatic tick(input bit r, input bit iv, input bit ordy);
      int ph;
      logic [2:0] e_rst, e_busy;
      @(negedge clk);
      rst = r; in_valid = iv; out_ready = ordy;
      #1;
      ph = m_act ? phase(m_t) : 0;
      e_rst = 3'b111;
      e_busy = 3'b000;
      for (int j = 0; j < 3; j++) begin
         if (ph >= 1 && ph <= NL) e_rst[j] = (j + 1 > ph);
         else if (ph == NL + 1)   e_rst[j] = (j >= NL);
      end
      if (ph >= 1 && ph <= NL) e_busy[ph-1] = 1'b1;
      check("in_ready",   32'(in_ready),   32'(ph == 0));
      check("capture_en", 32'(capture_en), 32'(ph == 0 && iv && !r));
      check("layer_rst",  32'(layer_rst),  32'(e_rst));
      check("layer_busy", 32'(layer_busy), 32'(e_busy));
      check("out_valid",  32'(out_valid),  32'(ph == NL + 1));
`ifdef NN_SEQ_PERF_EN
      check("frame_cnt",  32'(frame_cnt),  32'(m_frame));
      check("stall_cnt",  32'(stall_cnt),  32'(m_stall));
`else
      check("frame_cnt",  32'(frame_cnt),  32'd0);
      check("stall_cnt",  32'(stall_cnt),  32'd0);
`endif
      if (r) begin
         m_act = 0; m_frame = 0; m_stall = 0;
      end else if (ph == 0) begin
         if (iv) begin m_act = 1; m_t = 1; end
      end else if (ph == NL + 1) begin
         if (ordy) begin
            m_act = 0;
            m_frame = (m_frame + 1) % 65536;
         end else if (m_stall < 65535) begin
            m_stall++;
         end
      end else begin
         m_t++;
      end
      cyc++;
   endtask

   initial begin
      int cap_a, cap_b, done_a;
      bit r, iv, ordy;
      repeat (2) @(negedge clk);

      // Frame 1: full latency, 10 cycles of back-pressure.
      for (int c = 0; c <= 137; c++) begin
         tick(0, c == 0, c >= 136);
         if (c == 0)   check("f1_cap0",   32'(capture_en), 32'd1);
         if (c == 1)   check("f1_cap1",   32'(capture_en), 32'd0);
         if (c == 1)   check("f1_rst1",   32'(layer_rst),  32'b110);
         if (c == 27)  check("f1_rst27",  32'(layer_rst),  32'b110);
         if (c == 28)  check("f1_rst28",  32'(layer_rst),  32'b100);
         if (c == 92)  check("f1_rst92",  32'(layer_rst),  32'b100);
         if (c == 93)  check("f1_rst93",  32'(layer_rst),  32'b000);
         if (c == 125) check("f1_ov125",  32'(out_valid),  32'd0);
         if (c == 126) check("f1_ov126",  32'(out_valid),  32'd1);
         if (c == 136) check("f1_ov136",  32'(out_valid),  32'd1);
         if (c == 136) check("f1_rst136", 32'(layer_rst),  32'b000);
         if (c == 137) check("f1_ov137",  32'(out_valid),  32'd0);
         if (c == 137) check("f1_idle",   32'(in_ready),   32'd1);
      end
`ifdef NN_SEQ_PERF_EN
      check("f1_frames", 32'(frame_cnt), 32'd1);
      check("f1_stalls", 32'(stall_cnt), 32'd10);
`endif

      // Reset inside RUN2 discards the frame.
      for (int c = 0; c <= 52; c++) begin
         tick(c == 50, c == 0, 0);
         if (c == 51) check("rst_lrst", 32'(layer_rst), 32'b111);
         if (c == 51) check("rst_ov",   32'(out_valid), 32'd0);
      end

      // Fresh frame with an ignored in_valid pulse during RUN2.
      for (int c = 0; c <= 127; c++) begin
         tick(0, c == 0 || c == 60, 1);
         if (c == 60)  check("r2_rdy",  32'(in_ready),   32'd0);
         if (c == 60)  check("r2_cap",  32'(capture_en), 32'd0);
         if (c == 125) check("r2_ov125", 32'(out_valid), 32'd0);
         if (c == 126) check("r2_ov126", 32'(out_valid), 32'd1);
         if (c == 127) check("r2_ov127", 32'(out_valid), 32'd0);
      end

      // Back-to-back frames with in_valid and out_ready held high.
      tick(1, 0, 0);
      cap_a = -1; cap_b = -1; done_a = -1;
      for (int c = 0; c <= 255; c++) begin
         tick(0, 1, 1);
         if (capture_en) begin
            if (cap_a < 0) cap_a = c;
            else if (cap_b < 0) cap_b = c;
         end
         if (out_valid && done_a < 0) done_a = c;
      end
      check("b2b_cap_a",  32'(cap_a),  32'd0);
      check("b2b_done_a", 32'(done_a), 32'd126);
      check("b2b_cap_b",  32'(cap_b),  32'd127);
`ifdef NN_SEQ_PERF_EN
      check("b2b_frames", 32'(frame_cnt), 32'd2);
`endif

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         r    = ($urandom_range(0, 599) == 0);
         iv   = ($urandom_range(0, 3) == 0) && !r;
         ordy = ($urandom_range(0, 2) != 0);
         tick(r, iv, ordy);
      end

      // Single-layer build.
      for (int c = -2; c <= 30; c++) begin
         @(negedge clk);
         rst1 = (c < 0); iv1 = (c == 0); ordy1 = (c >= 29);
         #1;
         if (c >= 0) begin
            check("n1_lrst_hi", 32'(lrst1[2:1]), 32'b11);
            if (c == 0)  check("n1_cap0",   32'(cap1),  32'd1);
            if (c == 27) check("n1_busy27", 32'(busy1), 32'b001);
            if (c == 27) check("n1_ov27",   32'(ov1),   32'd0);
            if (c == 28) check("n1_ov28",   32'(ov1),   32'd1);
            if (c == 28) check("n1_lrst28", 32'(lrst1), 32'b110);
            if (c == 30) check("n1_ov30",   32'(ov1),   32'd0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Frame-level controller for a chain of up to three accumulate-then-ReLU dense layers.
- Each dense layer has no start input. It begins accumulating from its own reset: one input element per clock for IN_SIZE cycles, then one ReLU cycle.
- This block owns each layer's reset. It releases the layers one at a time, in order, holding each one released for exactly its required cycle count.
- It handshakes frames in from the feature front-end and presents the final result to the classifier/argmax stage.

Parameters:
- NUM_LAYERS, 3, number of active layers (1..3); unused layer_rst bits are held at 1.
- IN_SIZE_1, 26, input length of layer 1 (layer 1 runs IN_SIZE_1+1 cycles).
- IN_SIZE_2, 64, input length of layer 2.
- IN_SIZE_3, 32, input length of layer 3.
- CNT_W, 8, run-counter width; must be at least clog2(max IN_SIZE_k + 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  feature vector available upstream.
- in_ready  out  1  sequencer accepts a frame.
- capture_en  out  1  one-cycle latch strobe for the layer-1 input register.
- layer_rst  out  3  per-layer synchronous reset; bit k drives layer k+1.
- layer_busy  out  3  one-hot; bit k=1 while layer k+1 is accumulating or applying ReLU.
- out_valid  out  1  final layer output stable and valid.
- out_ready  in  1  downstream accepts the result.
- frame_cnt  out  16  completed-frame counter (optional feature).
- stall_cnt  out  16  output back-pressure cycles (optional feature).

Behaviour:
- States: IDLE, RUN1, RUN2, RUN3, DONE. The FSM is Moore: every output except capture_en is decoded from the state register.
- Reset values: state=IDLE, run counter=0, in_ready=1, capture_en=0, layer_rst=3'b111, layer_busy=0, out_valid=0, frame_cnt=0, stall_cnt=0.
- IDLE:
  - in_ready=1 and layer_rst=111.
  - If in_valid, then capture_en=1 in the same cycle (combinational AND) and the next state is RUN1 with the counter cleared.
- RUNk:
  - layer_rst[k-1]=0 and every earlier layer is also 0, so their outputs are held for use as inputs. Every later layer is held at 1.
  - layer_busy[k-1]=1.
  - The counter increments each cycle.
  - When counter==IN_SIZE_k (the state has then lasted IN_SIZE_k+1 cycles), the counter clears. The next state is RUN(k+1), or DONE if k==NUM_LAYERS.
- DONE:
  - layer_rst=0 for all active layers, so outputs are frozen post-ReLU (ReLU is idempotent).
  - out_valid=1 and in_ready=0.
  - If out_ready, the next state is IDLE. The layers are reset in the following cycle.
- Latency with defaults: handshake in cycle 0; RUN1 covers cycles 1–27, RUN2 cycles 28–92, RUN3 cycles 93–125; out_valid is first high in cycle 126.
- out_ready high before DONE has no effect. When out_ready is high on the first DONE cycle, DONE lasts exactly one cycle.
- in_valid while not in IDLE is ignored (in_ready=0, no capture_en).
- Back-to-back frames: an accept is possible in the IDLE cycle right after DONE. There is no overlap between frames.
- rst asserted in any state returns all outputs to their reset values on the next edge. A partial frame is discarded and no out_valid is produced.
- NUM_LAYERS=1 or 2: RUN states beyond NUM_LAYERS are never entered, and their layer_rst bits stay 1 in all states.
- Counter comparisons use an unsigned CNT_W-bit counter. The counter never wraps in legal configurations.

Optional Feature:
- Macro: NN_SEQ_PERF_EN.
- Defined:
  - frame_cnt increments by 1 on each out_valid&&out_ready and wraps modulo 2^16.
  - stall_cnt increments on each DONE cycle with out_ready=0 and saturates at 16'hFFFF.
  - Both counters clear only on rst.
- Undefined: frame_cnt and stall_cnt are driven constant 0 and no counter flops are inferred.

Test Plan:
- Reset, then in_valid=1 in cycle 0 → capture_en=1 in cycle 0 only; layer_rst=110 in cycles 1–27, 100 in cycles 28–92, 000 in cycles 93 onward; out_valid first high in cycle 126.
- Hold out_ready=0 for 10 cycles in DONE, then 1 → out_valid held 11 cycles with layer_rst=000 throughout; IDLE follows; stall_cnt=10 and frame_cnt=1 with NN_SEQ_PERF_EN.
- Pulse in_valid during RUN2 → in_ready=0, no capture_en, no state change; the frame completes at the normal cycle.
- Assert rst at cycle 50 (inside RUN2) → next cycle state=IDLE, layer_rst=111, out_valid stays 0; a new frame accepted afterwards completes after 126 cycles.
- NUM_LAYERS=1 → out_valid in cycle 28; layer_rst[2:1]=11 throughout.
- Two frames back-to-back with out_ready=1 and in_valid=1 held → second capture_en exactly one cycle after the first DONE cycle; frame_cnt=2.
